// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder issue stage.
// Holds IEEE-754 single-precision field positions, the timeout result word,
// the issue FSM state encoding, the buffered operand pair type and the
// special-operand classifier.
package fp_pkg;

  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  // Inf or NaN: the exponent field is all ones.
  function automatic logic is_special(input logic [31:0] word);
    return word[EXP_MSB:EXP_LSB] == EXP_ALL1;
  endfunction

endpackage

// File: rtl/fp_add_issue_if.sv
// Handshake bundle around the adder issue stage.
// Carries the operand-pair input stream, the adder start/done interface and
// the result output stream. slave = issue stage, master = its environment.
interface fp_add_issue_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_available;
  logic        add_exception;
  logic [31:0] add_sum;
  logic        add_done;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_exc;
  logic        out_timeout;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, add_done, out_ready,
    output in_ready, add_a, add_b, add_available, add_exception,
           out_valid, out_sum, out_exc, out_timeout
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, add_done, out_ready,
    input  in_ready, add_a, add_b, add_available, add_exception,
           out_valid, out_sum, out_exc, out_timeout
  );

endinterface

// File: rtl/fp_pair_fifo.sv
// DEPTH-entry synchronous FIFO of 64-bit operand pairs with occupancy level.
// Ports: clk/reset (sync, active-low), push/wdat, pop/rdat (head is visible
// combinationally), full, empty, level. Caller must not push when full or pop when empty.
module fp_pair_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  pair_t                  wdat,
  output pair_t                  rdat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdat;
  end

  assign rdat  = mem[rptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/fp_add_issue.sv
// Issue stage in front of the FP adder: buffers operand pairs, issues one at a
// time, waits for done (or a watchdog timeout) and returns the result.
// Ports: clk, reset (sync, active-low), bus (in/adder/out streams), busy, fifo_level.
module fp_add_issue #(
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] QNAN    = fp_pkg::QNAN
) (
  input  logic                   clk,
  input  logic                   reset,
  fp_add_issue_if.slave          bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  import fp_pkg::*;

  // Watchdog only needs to reach TIMEOUT-1.
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          push, pop, fifo_full, fifo_empty;
  logic          fin, fin_tmo;
  pair_t         in_pair, head;

  logic [31:0]   add_a_q, add_b_q, out_sum_q;
  logic          add_exc_q, out_exc_q, out_tmo_q;

  assign in_pair = '{a: bus.in_a, b: bus.in_b};
  assign push    = bus.in_valid & ~fifo_full;

  fp_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdat  (in_pair),
    .rdat  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd;
    pop       = 1'b0;
    fin       = 1'b0;
    fin_tmo   = 1'b0;
    case (state)
      // A done still high from a previous (possibly timed-out) pair blocks
      // issue, so a late done can never be credited to the next pair.
      IDLE: begin
        if (!fifo_empty && !bus.add_done) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wd_nxt    = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.add_done) begin
          fin       = 1'b1;
          state_nxt = HOLD;
        end else begin
          wd_nxt = wd + 1'b1;
          // ISSUE plus TIMEOUT-1 WAIT cycles, then the result is forced.
          if (wd_nxt == WW'(TIMEOUT - 1)) begin
            fin       = 1'b1;
            fin_tmo   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wd        <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_exc_q <= 1'b0;
      out_sum_q <= '0;
      out_exc_q <= 1'b0;
      out_tmo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      if (pop) begin
        add_a_q   <= head.a;
        add_b_q   <= head.b;
        add_exc_q <= is_special(head.a) | is_special(head.b);
      end
      if (fin) begin
        out_sum_q <= fin_tmo ? QNAN : bus.add_sum;
        out_exc_q <= add_exc_q;
        out_tmo_q <= fin_tmo;
      end
    end
  end

  assign bus.in_ready      = ~fifo_full;
  assign bus.add_a         = add_a_q;
  assign bus.add_b         = add_b_q;
  assign bus.add_exception = add_exc_q;
  assign bus.add_available = (state == ISSUE);
  assign bus.out_valid     = (state == HOLD);
  assign bus.out_sum       = out_sum_q;
  assign bus.out_exc       = out_exc_q;
  assign bus.out_timeout   = out_tmo_q;
  assign busy              = (state != IDLE);

endmodule
